// File: rtl/sad_min_tracker.sv
// Accumulates per-beat abs-diff rows into candidate SADs and tracks the raster-first minimum and its MV.
// Optional SAD_TRACE_EN exposes a per-candidate debug stream (cand_valid, cand_sad_out, cand_x_out, cand_y_out).
module sad_min_tracker #(
   parameter int PIXEL    = 8,
   parameter int N        = 8,
   parameter int BLK_ROWS = 8,
   parameter int SEARCH_W = 16,
   parameter int SEARCH_H = 16,
   parameter int SAD_W    = 14,
   parameter int MV_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [N*PIXEL-1:0]   abs_in,
   input  logic                 abs_valid,
   output logic                 in_ready,
   output logic                 busy,
   output logic                 done,
   output logic [SAD_W-1:0]     best_sad,
   output logic [MV_W-1:0]      best_mv_x,
   output logic [MV_W-1:0]      best_mv_y
`ifdef SAD_TRACE_EN
   ,
   output logic [SAD_W-1:0]     cand_sad_out,
   output logic [MV_W-1:0]      cand_x_out,
   output logic [MV_W-1:0]      cand_y_out,
   output logic                 cand_valid
`endif
);

   localparam int RC_W = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;

   typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

   state_t            state, state_nxt;
   logic [SAD_W-1:0]  acc;
   logic [SAD_W-1:0]  cand_sad;
   logic [SAD_W-1:0]  row_sum;
   logic [RC_W-1:0]   row_cnt;
   logic [MV_W-1:0]   cand_x;
   logic [MV_W-1:0]   cand_y;
   logic              last_row;
   logic              last_col;
   logic              last_cand;
   logic              beat_ok;

   always_comb begin
      row_sum = '0;
      for (int unsigned i = 0; i < N; i++) begin
         row_sum = row_sum + SAD_W'(abs_in[i*PIXEL +: PIXEL]);
      end
   end

   always_comb begin
      last_row  = (row_cnt == RC_W'(BLK_ROWS - 1));
      last_col  = (cand_x == MV_W'(SEARCH_W - 1));
      last_cand = last_col && (cand_y == MV_W'(SEARCH_H - 1));
      beat_ok   = abs_valid && in_ready;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (abs_valid && last_row) state_nxt = COMPARE;
         end
         COMPARE: state_nxt = last_cand ? DONE : ACCUM;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         cand_sad  <= '0;
         row_cnt   <= '0;
         cand_x    <= '0;
         cand_y    <= '0;
         best_sad  <= '1;
         best_mv_x <= '0;
         best_mv_y <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  acc       <= '0;
                  row_cnt   <= '0;
                  cand_x    <= '0;
                  cand_y    <= '0;
                  best_sad  <= '1;
                  best_mv_x <= '0;
                  best_mv_y <= '0;
               end
            end
            ACCUM: begin
               if (beat_ok) begin
                  if (last_row) begin
                     cand_sad <= acc + row_sum;
                     acc      <= '0;
                     row_cnt  <= '0;
                  end else begin
                     acc     <= acc + row_sum;
                     row_cnt <= row_cnt + RC_W'(1);
                  end
               end
            end
            COMPARE: begin
               // strict less-than keeps the earliest raster candidate on ties
               if (cand_sad < best_sad) begin
                  best_sad  <= cand_sad;
                  best_mv_x <= cand_x;
                  best_mv_y <= cand_y;
               end
               if (!last_cand) begin
                  if (last_col) begin
                     cand_x <= '0;
                     cand_y <= cand_y + MV_W'(1);
                  end else begin
                     cand_x <= cand_x + MV_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SAD_TRACE_EN
   always_comb begin
      cand_valid   = (state == COMPARE);
      cand_sad_out = cand_sad;
      cand_x_out   = cand_x;
      cand_y_out   = cand_y;
   end
`endif

endmodule

// File: tb/tb_sad_min_tracker.sv
// Randomized self-checking bench for sad_min_tracker against a whole-search arithmetic model.
module tb_sad_min_tracker;

   localparam int PIXEL    = 8;
   localparam int N        = 8;
   localparam int BLK_ROWS = 8;
   localparam int SEARCH_W = 16;
   localparam int SEARCH_H = 16;
   localparam int SAD_W    = 14;
   localparam int MV_W     = 4;
   localparam int NCAND    = SEARCH_W * SEARCH_H;
   localparam int NBEAT    = NCAND * BLK_ROWS;
   localparam int ALL_ONES = (1 << SAD_W) - 1;
   localparam int GAPLESS_CYCLES = 1 + NCAND * (BLK_ROWS + 1) + 1;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [N*PIXEL-1:0] abs_in = '0;
   logic               abs_valid = 1'b0;
   logic               in_ready;
   logic               busy;
   logic               done;
   logic [SAD_W-1:0]   best_sad;
   logic [MV_W-1:0]    best_mv_x;
   logic [MV_W-1:0]    best_mv_y;
`ifdef SAD_TRACE_EN
   logic [SAD_W-1:0]   cand_sad_out;
   logic [MV_W-1:0]    cand_x_out;
   logic [MV_W-1:0]    cand_y_out;
   logic               cand_valid;
`endif

   sad_min_tracker #(
      .PIXEL(PIXEL), .N(N), .BLK_ROWS(BLK_ROWS), .SEARCH_W(SEARCH_W),
      .SEARCH_H(SEARCH_H), .SAD_W(SAD_W), .MV_W(MV_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abs_in(abs_in),
      .abs_valid(abs_valid), .in_ready(in_ready), .busy(busy), .done(done),
      .best_sad(best_sad), .best_mv_x(best_mv_x), .best_mv_y(best_mv_y)
`ifdef SAD_TRACE_EN
      , .cand_sad_out(cand_sad_out), .cand_x_out(cand_x_out),
      .cand_y_out(cand_y_out), .cand_valid(cand_valid)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {int x; int y; int sad;} trace_t;

   int total = 0;
   int bad   = 0;

   logic [N*PIXEL-1:0] beats [NBEAT];
   int     exp_sad [NCAND];
   int     exp_best, exp_x, exp_y;
   int     run_cycles, run_dones;
   bit     run_timeout;
   trace_t trace_q [$];

   task automatic fill_pattern(input int base, input int special_cand, input int special_val);
      for (int b = 0; b < NBEAT; b++) begin
         for (int l = 0; l < N; l++) begin
            beats[b][l*PIXEL +: PIXEL] = PIXEL'((b / BLK_ROWS == special_cand) ? special_val : base);
         end
      end
   endtask

   task automatic fill_random();
      for (int b = 0; b < NBEAT; b++) begin
         for (int l = 0; l < N; l++) beats[b][l*PIXEL +: PIXEL] = PIXEL'($urandom_range(255));
      end
   endtask

   // Whole-search reference: sum every candidate, keep the first strictly smaller one.
   task automatic build_model();
      int s;
      exp_best = ALL_ONES; exp_x = 0; exp_y = 0;
      for (int c = 0; c < NCAND; c++) begin
         s = 0;
         for (int r = 0; r < BLK_ROWS; r++)
            for (int l = 0; l < N; l++) s += int'(beats[c*BLK_ROWS + r][l*PIXEL +: PIXEL]);
         exp_sad[c] = s;
         if (s < exp_best) begin
            exp_best = s; exp_x = c % SEARCH_W; exp_y = c / SEARCH_W;
         end
      end
   endtask

   // Pulses start, feeds beats on accepted handshakes, counts done pulses; run_cycles counts start and done cycles inclusively.
   task automatic run_search(input int stall_pct, input int restart_at, input int abort_at_beat);
      int ptr = 0;
      int edges = 0;
      int tail = -1;
      bit acc;
      run_dones = 0; run_timeout = 1'b0; run_cycles = 0;
      trace_q.delete();
      @(negedge clk);
      start = 1'b1; abs_valid = 1'b1; abs_in = beats[0];
      acc = abs_valid && in_ready;
      forever begin
         @(posedge clk); #1;
         edges++;
         if (acc) ptr++;
         start = 1'b0;
`ifdef SAD_TRACE_EN
         if (cand_valid) trace_q.push_back('{int'(cand_x_out), int'(cand_y_out), int'(cand_sad_out)});
`endif
         if (done) begin
            run_dones++;
            if (run_dones == 1) begin
               run_cycles = edges + 1;
               tail = edges + 4;
            end
         end
         if (edges == tail) break;
         if (abort_at_beat >= 0 && ptr == abort_at_beat) break;
         if (edges > 30000) begin
            run_timeout = 1'b1;
            break;
         end
         abs_valid = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
         abs_in = (abs_valid && ptr < NBEAT) ? beats[ptr] : {$urandom, $urandom};
         if (edges == restart_at) start = 1'b1;
         acc = abs_valid && in_ready;
      end
      abs_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         abs_valid = 1'b1; abs_in = {$urandom, $urandom};
         @(negedge clk);
      end
      abs_valid = 1'b0;
      total++; if (best_sad !== SAD_W'(ALL_ONES)) begin bad++; $display("FAIL reset_best_sad got=%0d want=%0d", best_sad, ALL_ONES); end
      total++; if (best_mv_x !== '0 || best_mv_y !== '0) begin bad++; $display("FAIL reset_mv got=(%0d,%0d) want=(0,0)", best_mv_x, best_mv_y); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
   endtask

   task automatic test_uniform();
      fill_pattern(1, -1, 0);
      run_search(0, -1, -1);
      total++; if (run_timeout) begin bad++; $display("FAIL uniform_timeout got=timeout want=done"); end
      total++; if (best_sad !== SAD_W'(64)) begin bad++; $display("FAIL uniform_sad got=%0d want=64", best_sad); end
      total++; if (best_mv_x !== '0 || best_mv_y !== '0) begin bad++; $display("FAIL uniform_mv got=(%0d,%0d) want=(0,0)", best_mv_x, best_mv_y); end
      total++; if (run_cycles != GAPLESS_CYCLES) begin bad++; $display("FAIL uniform_latency got=%0d want=%0d", run_cycles, GAPLESS_CYCLES); end
      total++; if (run_dones != 1) begin bad++; $display("FAIL uniform_done_count got=%0d want=1", run_dones); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL uniform_busy_after got=%b want=0", busy); end
   endtask

   task automatic test_unique_min();
      fill_pattern(10, 3*SEARCH_W + 5, 2);
      run_search(0, -1, -1);
      total++; if (best_sad !== SAD_W'(128)) begin bad++; $display("FAIL unique_sad got=%0d want=128", best_sad); end
      total++; if (best_mv_x !== MV_W'(5) || best_mv_y !== MV_W'(3)) begin bad++; $display("FAIL unique_mv got=(%0d,%0d) want=(5,3)", best_mv_x, best_mv_y); end
      total++; if (run_dones != 1) begin bad++; $display("FAIL unique_done_count got=%0d want=1", run_dones); end
   endtask

   task automatic test_max_values();
      fill_pattern(255, -1, 0);
      run_search(0, -1, -1);
      total++; if (best_sad !== SAD_W'(16320)) begin bad++; $display("FAIL max_sad got=%0d want=16320", best_sad); end
      total++; if (best_mv_x !== '0 || best_mv_y !== '0) begin bad++; $display("FAIL max_mv got=(%0d,%0d) want=(0,0)", best_mv_x, best_mv_y); end
   endtask

   task automatic test_random_stalls();
      fill_random();
      build_model();
      run_search(0, -1, -1);
      total++; if (int'(best_sad) != exp_best) begin bad++; $display("FAIL random_sad got=%0d want=%0d", best_sad, exp_best); end
      total++; if (int'(best_mv_x) != exp_x || int'(best_mv_y) != exp_y) begin bad++; $display("FAIL random_mv got=(%0d,%0d) want=(%0d,%0d)", best_mv_x, best_mv_y, exp_x, exp_y); end
      total++; if (run_cycles != GAPLESS_CYCLES) begin bad++; $display("FAIL random_latency got=%0d want=%0d", run_cycles, GAPLESS_CYCLES); end
      run_search(40, 700, -1);
      total++; if (run_timeout) begin bad++; $display("FAIL stall_timeout got=timeout want=done"); end
      total++; if (int'(best_sad) != exp_best) begin bad++; $display("FAIL stall_sad got=%0d want=%0d", best_sad, exp_best); end
      total++; if (int'(best_mv_x) != exp_x || int'(best_mv_y) != exp_y) begin bad++; $display("FAIL stall_mv got=(%0d,%0d) want=(%0d,%0d)", best_mv_x, best_mv_y, exp_x, exp_y); end
      total++; if (run_dones != 1) begin bad++; $display("FAIL stall_done_count got=%0d want=1", run_dones); end
      total++; if (run_cycles <= GAPLESS_CYCLES) begin bad++; $display("FAIL stall_latency got=%0d want>%0d", run_cycles, GAPLESS_CYCLES); end
   endtask

   task automatic test_reset_mid_search();
      int done_seen = 0;
      fill_random();
      run_search(0, -1, 40*BLK_ROWS + 3);
      #2 rst_n = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL midreset_ctrl got=busy%b/rdy%b/done%b want=0/0/0", busy, in_ready, done); end
      total++; if (best_sad !== SAD_W'(ALL_ONES)) begin bad++; $display("FAIL midreset_best_sad got=%0d want=%0d", best_sad, ALL_ONES); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      total++; if (done_seen != 0) begin bad++; $display("FAIL midreset_no_done got=%0d want=0", done_seen); end
      fill_pattern(10, 3*SEARCH_W + 5, 2);
      build_model();
      run_search(0, -1, -1);
      total++; if (best_sad !== SAD_W'(128)) begin bad++; $display("FAIL rerun_sad got=%0d want=128", best_sad); end
      total++; if (best_mv_x !== MV_W'(5) || best_mv_y !== MV_W'(3)) begin bad++; $display("FAIL rerun_mv got=(%0d,%0d) want=(5,3)", best_mv_x, best_mv_y); end
      total++; if (run_dones != 1) begin bad++; $display("FAIL rerun_done_count got=%0d want=1", run_dones); end
`ifdef SAD_TRACE_EN
      total++; if (trace_q.size() != NCAND) begin bad++; $display("FAIL trace_count got=%0d want=%0d", trace_q.size(), NCAND); end
      for (int c = 0; c < trace_q.size() && c < NCAND; c++) begin
         total++;
         if (trace_q[c].x != c % SEARCH_W || trace_q[c].y != c / SEARCH_W || trace_q[c].sad != exp_sad[c]) begin
            bad++;
            $display("FAIL trace_entry%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", c, trace_q[c].x, trace_q[c].y,
                     trace_q[c].sad, c % SEARCH_W, c / SEARCH_W, exp_sad[c]);
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_unique_min();
      test_max_values();
      test_random_stalls();
      test_reset_mid_search();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sad_min_tracker.md
Name: sad_min_tracker

Overview:
- Sits directly downstream of the PE array that emits per-PE absolute differences.
- Each beat carries one block row of N absolute differences for the current search candidate. These are summed over BLK_ROWS beats into a candidate SAD.
- Candidates are walked in raster order over the search window. The block tracks the minimum SAD and its motion-vector index, then signals completion to the ME controller.

Parameters:
- PIXEL, 8, width of one absolute difference
- N, 8, PEs per row (abs diffs per beat)
- BLK_ROWS, 8, beats per candidate
- SEARCH_W, 16, candidates per search row
- SEARCH_H, 16, search rows
- SAD_W, 14, SAD width; must be at least PIXEL+clog2(N*BLK_ROWS)
- MV_W, 4, width of each MV index; must be at least clog2(max(SEARCH_W,SEARCH_H))

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a search
- abs_in  in  N*PIXEL  packed abs diffs; PE0 in LSBs
- abs_valid  in  1  abs_in beat valid
- in_ready  out  1  block accepts a beat this cycle
- busy  out  1  search in progress
- done  out  1  one-cycle pulse; result valid
- best_sad  out  SAD_W  minimum SAD found
- best_mv_x  out  MV_W  column index of best candidate
- best_mv_y  out  MV_W  row index of best candidate

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. All flops clear on reset.
- Reset values:
  - state=IDLE; in_ready=0, busy=0, done=0.
  - best_sad = all ones; best_mv_x=0, best_mv_y=0.
  - Internal accumulator, row_cnt, cand_x and cand_y all 0.
- FSM states: IDLE, ACCUM, COMPARE, DONE.
- IDLE:
  - On start: acc, row_cnt, cand_x and cand_y clear; best_sad is set to all ones; best_mv is set to 0; go to ACCUM.
  - abs_valid is ignored in IDLE.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when abs_valid && in_ready.
  - row_sum = unsigned sum of the N PIXEL-bit lanes, zero-extended to SAD_W.
  - If row_cnt < BLK_ROWS-1: acc <= acc+row_sum and row_cnt increments.
  - If row_cnt == BLK_ROWS-1: cand_sad <= acc+row_sum; acc and row_cnt clear; go to COMPARE.
  - Gaps are allowed: with no valid beat, state and acc hold.
- COMPARE (exactly one cycle):
  - in_ready=0.
  - If cand_sad < best_sad (strict): best_sad <= cand_sad and best_mv <= (cand_x, cand_y). Ties keep the earlier raster candidate.
  - If cand_x == SEARCH_W-1 and cand_y == SEARCH_H-1: go to DONE.
  - Otherwise advance raster order: cand_x wraps to 0 and increments cand_y when cand_x == SEARCH_W-1. Return to ACCUM.
- DONE (one cycle):
  - done=1, in_ready=0; then go to IDLE.
  - best_* hold until the next start.
- busy=1 in ACCUM, COMPARE and DONE.
- start while busy: ignored.
- Total cycles from start to done, with no gaps: 1 + SEARCH_W*SEARCH_H*(BLK_ROWS+1) + 1.
- Arithmetic: unsigned. Overflow is impossible given the SAD_W constraint; no saturation logic.
- Reset asserted mid-search: immediate return to reset values. No done is issued.

Optional Feature:
- Macro: SAD_TRACE_EN.
- When defined:
  - Extra outputs cand_sad_out [SAD_W], cand_x_out [MV_W], cand_y_out [MV_W] and cand_valid [1].
  - cand_valid pulses for one cycle during COMPARE, carrying that candidate's SAD and index, for per-candidate debug and cost logging.
- When undefined: these ports and their registers do not exist; core behaviour is identical.

Test Plan:
- Reset, then idle:
  - Stimulus: rst_n low, then high with no start.
  - Required: best_sad=16383, best_mv=(0,0), busy=0, in_ready=0, done=0; abs_valid beats have no effect.
- Uniform search:
  - Stimulus: every lane =1 for all beats.
  - Required: each cand_sad=64; best_sad=64; best_mv=(0,0) by tie rule. done arrives exactly 2306 cycles after start with back-to-back valid.
- Unique minimum:
  - Stimulus: all lanes =10 except candidate (5,3), whose lanes =2.
  - Required: best_sad=128, best_mv_x=5, best_mv_y=3.
- Maximum values:
  - Stimulus: all lanes =255.
  - Required: best_sad=16320, no wrap.
- Stalls and ignored start:
  - Stimulus: abs_valid toggles randomly; start pulsed mid-search.
  - Required: same result as the gap-free run; second start ignored; exactly one done pulse.
- Reset mid-search, then rerun:
  - Stimulus: rst_n low during candidate 40; no done; then a fresh start with the unique-minimum pattern.
  - Required: correct result (128,5,3). With SAD_TRACE_EN: 256 cand_valid pulses, in raster index order.
